// File: rtl/esm_pkg.sv
// Shared constants and helpers for the multi-port buffer-slot index core.
package esm_pkg;

    localparam int unsigned POLICY_LOWEST = 0;
    localparam int unsigned POLICY_RR     = 1;

    // Index width for a slot count; never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/esm_slot_picker.sv
// Masked priority encoder: first slot at or after start (with wrap) that is free and not excluded.
module esm_slot_picker
    import esm_pkg::*;
#(
    parameter  int unsigned bs = 16,
    localparam int unsigned BW = idx_bits(bs)
) (
    input  logic [bs-1:0] free_mask,
    input  logic [bs-1:0] excl_mask,
    input  logic [BW-1:0] start,
    output logic          found,
    output logic [BW-1:0] index
);

    logic [bs-1:0] avail;
    logic [BW-1:0] cand;

    assign avail = free_mask & ~excl_mask;

    // Walk offsets from the far end so the nearest hit after start wins; bs is a power of two so BW-bit add wraps.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = bs - 1; k >= 0; k--) begin
            cand = start + BW'(k);
            if (avail[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/esm_core_mp.sv
// Multi-port buffer-slot index core: tracks free slots, offers them on AP ports, accepts releases on RP ports.
module esm_core_mp
    import esm_pkg::*;
#(
    parameter  int unsigned bs     = 16,
    parameter  int unsigned RP     = 2,
    parameter  int unsigned AP     = 2,
    parameter  int unsigned POLICY = 0,
    localparam int unsigned BW     = idx_bits(bs),
    localparam int unsigned CW     = BW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RP-1:0]    rel_valid,
    input  logic [RP*BW-1:0] rel_index,
    output logic [AP-1:0]    alloc_valid,
    output logic [AP*BW-1:0] alloc_index,
    input  logic [AP-1:0]    alloc_ready,
    output logic [CW-1:0]    free_count,
    output logic             empty,
    output logic             err_double_free
);

    logic [bs-1:0] free_map;
    logic [BW-1:0] rr_ptr;
    logic [BW-1:0] start;
    logic [AP-1:0] open_vec;
    logic [AP-1:0] take;
    logic [BW-1:0] pick [AP];
    logic [bs-1:0] taken_mask;
    logic [bs-1:0] held_mask;
    logic [bs-1:0] rel_mask;
    logic [bs-1:0] next_free;
    logic          err_c;
    logic [BW-1:0] last_pick;

    assign start = (POLICY == POLICY_RR) ? rr_ptr : '0;

    // Picker cascade: each port excludes slots already chosen by lower ports this cycle.
    for (genvar j = 0; j < AP; j++) begin : g_port
        logic [bs-1:0] excl_in;
        logic [bs-1:0] excl_out;
        logic          found;

        if (j == 0) begin : g_first
            assign excl_in = '0;
        end else begin : g_rest
            assign excl_in = g_port[j-1].excl_out;
        end

        assign open_vec[j] = ~alloc_valid[j] | alloc_ready[j];

        esm_slot_picker #(.bs(bs)) u_pick (
            .free_mask (free_map),
            .excl_mask (excl_in),
            .start     (start),
            .found     (found),
            .index     (pick[j])
        );

        assign take[j]  = open_vec[j] & found;
        assign excl_out = take[j] ? (excl_in | (bs'(1) << pick[j])) : excl_in;
    end

    assign taken_mask = g_port[AP-1].excl_out;

    // Release legality: slot must be outstanding, not sitting in an offer, and not repeated by a lower port.
    always_comb begin
        logic [BW-1:0] ri;
        logic          dup;
        held_mask = '0;
        rel_mask  = '0;
        err_c     = 1'b0;
        ri        = '0;
        dup       = 1'b0;
        for (int j = 0; j < AP; j++) begin
            if (alloc_valid[j]) held_mask[alloc_index[j*BW +: BW]] = 1'b1;
        end
        for (int i = 0; i < RP; i++) begin
            ri  = rel_index[i*BW +: BW];
            dup = 1'b0;
            for (int k = 0; k < i; k++) begin
                if (rel_valid[k] && (rel_index[k*BW +: BW] == ri)) dup = 1'b1;
            end
            if (rel_valid[i]) begin
                if (free_map[ri] || held_mask[ri] || dup) err_c = 1'b1;
                else                                      rel_mask[ri] = 1'b1;
            end
        end
    end

    always_comb begin
        last_pick = '0;
        for (int j = 0; j < AP; j++) begin
            if (take[j]) last_pick = pick[j];
        end
    end

    assign next_free = (free_map & ~taken_mask) | rel_mask;
    assign empty     = ~(|free_map) & ~(|alloc_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            free_map        <= '1;
            alloc_valid     <= '0;
            alloc_index     <= '0;
            free_count      <= CW'(bs);
            err_double_free <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            free_map        <= next_free;
            free_count      <= CW'($countones(next_free));
            err_double_free <= err_double_free | err_c;
            if (|take) rr_ptr <= last_pick + BW'(1);
            for (int j = 0; j < AP; j++) begin
                if (open_vec[j]) begin
                    alloc_valid[j] <= take[j];
                    if (take[j]) alloc_index[j*BW +: BW] <= pick[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_esm_core_mp.sv
// Table-driven bench for esm_core_mp: lowest-first and round-robin instances share stimulus.
module tb_esm_core_mp;

    logic       clk;
    logic       rst;
    logic [1:0] rel_valid;
    logic [7:0] rel_index;
    logic [1:0] alloc_ready;

    logic [1:0] av0, av1;
    logic [7:0] ai0, ai1;
    logic [4:0] fc0, fc1;
    logic       em0, em1;
    logic       er0, er1;

    esm_core_mp #(.bs(16), .RP(2), .AP(2), .POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .rel_valid(rel_valid), .rel_index(rel_index),
        .alloc_valid(av0), .alloc_index(ai0), .alloc_ready(alloc_ready),
        .free_count(fc0), .empty(em0), .err_double_free(er0)
    );

    esm_core_mp #(.bs(16), .RP(2), .AP(2), .POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .rel_valid(rel_valid), .rel_index(rel_index),
        .alloc_valid(av1), .alloc_index(ai1), .alloc_ready(alloc_ready),
        .free_count(fc1), .empty(em1), .err_double_free(er1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic [3:0] ri0;
        logic [3:0] ri1;
        logic [1:0] ar;
        logic [1:0] ev;
        logic [3:0] ei0;
        logic [3:0] ei1;
        logic [4:0] ec;
        logic       ee;
        logic       er;
    } vec_t;

    vec_t tab[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, input logic [1:0] rv, input int r0, input int r1,
                                input logic [1:0] ar, input logic [1:0] ev, input int e0, input int e1,
                                input int ec, input logic ee, input logic er);
        vec_t v;
        v.rst = r;   v.rv = rv;  v.ri0 = 4'(r0); v.ri1 = 4'(r1); v.ar = ar;
        v.ev  = ev;  v.ei0 = 4'(e0); v.ei1 = 4'(e1); v.ec = 5'(ec);
        v.ee  = ee;  v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, req);
        end
    endtask

    // Drive each row, queue its expectation, and compare once the edge has produced the outputs.
    task automatic run_phase(input string ph, input int sel);
        vec_t       e;
        logic [1:0] av;
        logic [7:0] ai;
        logic [4:0] fc;
        logic       em, er;
        for (int r = 0; r < tab.size(); r++) begin
            rst         = tab[r].rst;
            rel_valid   = tab[r].rv;
            rel_index   = {tab[r].ri1, tab[r].ri0};
            alloc_ready = tab[r].ar;
            exp_q.push_back(tab[r]);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            av = (sel == 0) ? av0 : av1;
            ai = (sel == 0) ? ai0 : ai1;
            fc = (sel == 0) ? fc0 : fc1;
            em = (sel == 0) ? em0 : em1;
            er = (sel == 0) ? er0 : er1;
            chk({ph, " alloc_valid"}, r, int'(av), int'(e.ev));
            if (e.ev[0]) chk({ph, " alloc_index0"}, r, int'(ai[3:0]), int'(e.ei0));
            if (e.ev[1]) chk({ph, " alloc_index1"}, r, int'(ai[7:4]), int'(e.ei1));
            if (e.rst)   chk({ph, " alloc_index_rst"}, r, int'(ai), 0);
            chk({ph, " free_count"}, r, int'(fc), int'(e.ec));
            chk({ph, " empty"}, r, int'(em), int'(e.ee));
            chk({ph, " err_double_free"}, r, int'(er), int'(e.er));
        end
        tab.delete();
    endtask

    initial begin
        rst         = 1'b1;
        rel_valid   = '0;
        rel_index   = '0;
        alloc_ready = '0;

        // Lowest-index-first: fill, drain to empty, single release, double releases, reset recovery.
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 14, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 2, 3, 12, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 4, 5, 10, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 6, 7, 8, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 8, 9, 6, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 10, 11, 4, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 12, 13, 2, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 14, 15, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0));
        tab.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tab.push_back(mk(0, 3, 5, 5, 0, 0, 0, 0, 1, 0, 1));
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1));
        tab.push_back(mk(0, 3, 3, 5, 0, 1, 5, 0, 1, 0, 1));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 14, 0, 0));
        tab.push_back(mk(0, 1, 0, 0, 0, 3, 0, 1, 14, 0, 1));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0));
        run_phase("p0", 0);

        // Round-robin: freed low slots are skipped until the pointer wraps past 15.
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 14, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 2, 3, 12, 0, 0));
        tab.push_back(mk(0, 3, 0, 1, 0, 3, 2, 3, 14, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 3, 4, 3, 13, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 5, 6, 11, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 7, 8, 9, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 9, 10, 7, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 11, 12, 5, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 13, 14, 3, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 3, 15, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        run_phase("p1", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
